// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and transmitter-side signals of the shared UART transmit path.
// Signals:
//   req, req_data    - per-requester request level and byte (requester i on bits [8i+7:8i])
//   gnt, owner       - one-hot grant pulse and index of the last granted requester
//   Tx_DATA, Tx_WR   - byte and write strobe towards the transmitter
//   Tx_EN, Tx_BUSY   - transmitter enable and busy feedback
// Modports: master = arbiter, slave = requesters plus transmitter.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] gnt;
  logic [2:0] owner;
  logic [7:0] Tx_DATA;
  logic Tx_WR;
  logic Tx_EN;
  logic Tx_BUSY;
  modport master (output gnt, owner, Tx_DATA, Tx_WR, Tx_EN, input req, req_data, Tx_BUSY);
  modport slave (input gnt, owner, Tx_DATA, Tx_WR, Tx_EN, output req, req_data, Tx_BUSY);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_transmitter among NUM_REQ requesters.
// Ports:
//   clock, reset  - rising-edge clock, asynchronous active-low reset
//   arb_en        - 1 lets the arbiter accept new bytes
//   req_urgent    - only with UART_ARB_URGENT_EN: qualifies req[0] as an unconditional winner
//   bus           - uart_tx_arbiter_if.master (requester handshake and transmitter Tx_* signals)
//   arb_busy      - high while a byte is being handed to the transmitter
//   err_timeout   - sticky, Tx_BUSY never rose after Tx_WR; cleared only by reset
// Optional feature macro: UART_ARB_URGENT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAX_BURST = 4,
  parameter int START_TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic arb_en,
`ifdef UART_ARB_URGENT_EN
  input  logic req_urgent,
`endif
  uart_tx_arbiter_if.master bus,
  output logic arb_busy,
  output logic err_timeout
);
  localparam int CW = $clog2(START_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] burst_cnt, burst_n;
  logic hold, hold_n, hold_ok, urgent, wr_n, err_n;
  logic [2:0] rot, sel, pick, owner_n;
  logic [7:0] req8, data_n;
  logic [63:0] data64;
  logic [NUM_REQ-1:0] gnt_n;
  // Widened copies so a 3-bit index always selects in range for any NUM_REQ.
  assign req8 = 8'(bus.req);
  assign data64 = 64'(bus.req_data);
`ifdef UART_ARB_URGENT_EN
  assign urgent = bus.req[0] & req_urgent;
`else
  assign urgent = 1'b0;
`endif
  // First set request after owner, wrapping; the lowest offset wins.
  always_comb begin
    rot = bus.owner;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req8[3'((int'(bus.owner) + k) % NUM_REQ)]) rot = 3'((int'(bus.owner) + k) % NUM_REQ);
  end
  // hold is cleared by reset and by a start timeout so the next pick rotates.
  assign hold_ok = hold && req8[bus.owner] && burst_cnt < 4'(MAX_BURST - 1);
  assign sel = hold_ok ? bus.owner : rot;
  assign pick = urgent ? 3'd0 : sel;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    burst_n = burst_cnt;
    hold_n = hold;
    owner_n = bus.owner;
    data_n = bus.Tx_DATA;
    gnt_n = '0;
    wr_n = 1'b0;
    err_n = err_timeout;
    case (state)
      IDLE:
        if (arb_en && |bus.req) begin
          state_n = LOAD;
          gnt_n = NUM_REQ'(1) << pick;
          data_n = data64[{pick, 3'b000} +: 8];
          // An urgent grant leaves the rotation position untouched.
          if (!urgent) begin
            owner_n = sel;
            burst_n = hold_ok ? burst_cnt + 4'd1 : 4'd0;
            hold_n = 1'b1;
          end
        end
      LOAD: begin
        state_n = WAIT_START;
        wr_n = 1'b1;
        // The LOAD cycle itself counts as the first timeout cycle.
        cnt_n = CW'(1);
      end
      WAIT_START:
        if (bus.Tx_BUSY) state_n = WAIT_DONE;
        else if (cnt >= CW'(START_TIMEOUT - 1)) begin
          state_n = IDLE;
          err_n = 1'b1;
          burst_n = 4'd0;
          hold_n = 1'b0;
        end else cnt_n = cnt + 1'b1;
      WAIT_DONE: state_n = bus.Tx_BUSY ? WAIT_DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      burst_cnt <= '0;
      hold <= 1'b0;
      bus.owner <= 3'(NUM_REQ - 1);
      bus.gnt <= '0;
      bus.Tx_DATA <= '0;
      bus.Tx_WR <= 1'b0;
      bus.Tx_EN <= 1'b0;
      arb_busy <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      burst_cnt <= burst_n;
      hold <= hold_n;
      bus.owner <= owner_n;
      bus.gnt <= gnt_n;
      bus.Tx_DATA <= data_n;
      bus.Tx_WR <= wr_n;
      bus.Tx_EN <= arb_en || state_n != IDLE;
      arb_busy <= state_n != IDLE;
      err_timeout <= err_n;
    end
endmodule
